// File: rtl/panel_prog_loader.sv
// Front-panel program loader for the Altair 8800 core: pauses the CPU and replays
// the operator's examine / deposit / deposit-next toggle sequence from a program ROM.
module panel_prog_loader #(
  parameter int GAP_LEN   = 16,
  parameter int PULSE_LEN = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  prg_sel,
  input  logic [8:0]  prg_len,
  input  logic [15:0] base_addr,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  addr_sw,
  output logic [7:0]  data_sw,
  output logic        examine_pb,
  output logic        deposit_pb,
  output logic        deposit_next_pb,
  output logic        pause_req,
  output logic        busy,
  output logic        done
);

  localparam int MAX_DWELL = (GAP_LEN > PULSE_LEN) ? GAP_LEN : PULSE_LEN;
  localparam int CW        = $clog2(MAX_DWELL) + 1;
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_EXAM_SETUP = 4'd1,
    ST_EXAM_PULSE = 4'd2,
    ST_EXAM_HOLD  = 4'd3,
    ST_FETCH      = 4'd4,
    ST_CAPTURE    = 4'd5,
    ST_DEP_SETUP  = 4'd6,
    ST_DEP_PULSE  = 4'd7,
    ST_DEP_HOLD   = 4'd8,
    ST_FINISH     = 4'd9
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [7:0]     idx_r, idx_s;
  logic [8:0]     len_r, len_s;
  logic [2:0]     sel_r, sel_s;
  logic [15:0]    base_r, base_s;
  logic           start_q_r;

  logic [10:0]    rom_addr_r, rom_addr_s;
  logic [7:0]     addr_sw_r, addr_sw_s;
  logic [7:0]     data_sw_r, data_sw_s;
  logic           examine_r, examine_s;
  logic           deposit_r, deposit_s;
  logic           deposit_next_r, deposit_next_s;
  logic           pause_r, pause_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;

  logic           start_edge_s;
  logic [8:0]     len_clamped_s;
  logic           dwell_done_s;
  logic           active_s;

  function automatic logic [CW-1:0] dwell_last(input state_t st);
    case (st)
      ST_EXAM_SETUP, ST_EXAM_HOLD, ST_DEP_SETUP, ST_DEP_HOLD: dwell_last = GAP_LAST;
      ST_EXAM_PULSE, ST_DEP_PULSE:                           dwell_last = PULSE_LAST;
      default:                                               dwell_last = {CW{1'b0}};
    endcase
  endfunction

  assign start_edge_s  = start & ~start_q_r;
  assign len_clamped_s = (prg_len > 9'd256) ? 9'd256 : prg_len;
  assign dwell_done_s  = (cnt_r == {CW{1'b0}});

  // Next-state, load-context and dwell-counter logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    len_s   = len_r;
    sel_s   = sel_r;
    base_s  = base_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          sel_s   = prg_sel;
          len_s   = len_clamped_s;
          base_s  = base_addr;
          idx_s   = 8'd0;
          state_s = (len_clamped_s == 9'd0) ? ST_FINISH : ST_EXAM_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXAM_SETUP: state_s = dwell_done_s ? ST_EXAM_PULSE : ST_EXAM_SETUP;
      ST_EXAM_PULSE: state_s = dwell_done_s ? ST_EXAM_HOLD  : ST_EXAM_PULSE;
      ST_EXAM_HOLD:  state_s = dwell_done_s ? ST_FETCH      : ST_EXAM_HOLD;
      ST_FETCH:      state_s = ST_CAPTURE;
      ST_CAPTURE:    state_s = ST_DEP_SETUP;
      ST_DEP_SETUP:  state_s = dwell_done_s ? ST_DEP_PULSE  : ST_DEP_SETUP;
      ST_DEP_PULSE:  state_s = dwell_done_s ? ST_DEP_HOLD   : ST_DEP_PULSE;
      ST_DEP_HOLD: begin
        if (!dwell_done_s) begin
          state_s = ST_DEP_HOLD;
        end else if ({1'b0, idx_r} == (len_r - 9'd1)) begin
          state_s = ST_FINISH;
        end else begin
          idx_s   = idx_r + 8'd1;
          state_s = ST_FETCH;
        end
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase

    cnt_s = cnt_r;
    if (state_s != state_r) begin
      cnt_s = dwell_last(state_s);
    end else if (!dwell_done_s) begin
      cnt_s = cnt_r - CW'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Output values for the upcoming state, so every output leaves a flop aligned with its state.
  always_comb begin
    active_s       = (state_s != ST_IDLE) && (state_s != ST_FINISH);
    pause_s        = active_s;
    busy_s         = (state_s != ST_IDLE);
    done_s         = (state_s == ST_FINISH);
    addr_sw_s      = active_s ? base_s[15:8] : 8'd0;
    examine_s      = (state_s == ST_EXAM_PULSE);
    deposit_s      = (state_s == ST_DEP_PULSE) && (idx_s == 8'd0);
    deposit_next_s = (state_s == ST_DEP_PULSE) && (idx_s != 8'd0);
    rom_addr_s     = (state_s == ST_IDLE) ? 11'd0 : {sel_s, idx_s};
    data_sw_s      = 8'd0;
    case (state_s)
      ST_EXAM_SETUP, ST_EXAM_PULSE, ST_EXAM_HOLD: data_sw_s = base_s[7:0];
      ST_DEP_SETUP: begin
        // ROM byte is valid during CAPTURE; it is taken on the way out of that state.
        if (state_r == ST_CAPTURE) begin
          data_sw_s = rom_data;
        end else begin
          data_sw_s = data_sw_r;
        end
      end
      ST_FETCH, ST_CAPTURE, ST_DEP_PULSE, ST_DEP_HOLD: data_sw_s = data_sw_r;
      default: data_sw_s = 8'd0;
    endcase
  end

  // State, context and output registers; the start history resets high so a held start is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CW{1'b0}};
      idx_r          <= 8'd0;
      len_r          <= 9'd0;
      sel_r          <= 3'd0;
      base_r         <= 16'd0;
      start_q_r      <= 1'b1;
      rom_addr_r     <= 11'd0;
      addr_sw_r      <= 8'd0;
      data_sw_r      <= 8'd0;
      examine_r      <= 1'b0;
      deposit_r      <= 1'b0;
      deposit_next_r <= 1'b0;
      pause_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      idx_r          <= idx_s;
      len_r          <= len_s;
      sel_r          <= sel_s;
      base_r         <= base_s;
      start_q_r      <= start;
      rom_addr_r     <= rom_addr_s;
      addr_sw_r      <= addr_sw_s;
      data_sw_r      <= data_sw_s;
      examine_r      <= examine_s;
      deposit_r      <= deposit_s;
      deposit_next_r <= deposit_next_s;
      pause_r        <= pause_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
    end
  end

  assign rom_addr        = rom_addr_r;
  assign addr_sw         = addr_sw_r;
  assign data_sw         = data_sw_r;
  assign examine_pb      = examine_r;
  assign deposit_pb      = deposit_r;
  assign deposit_next_pb = deposit_next_r;
  assign pause_req       = pause_r;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule

// File: tb/tb_panel_prog_loader.sv
// Bench for panel_prog_loader: directed and randomized loads checked cycle by cycle
// against a timeline model computed from cycle offsets after the start edge.
module tb_panel_prog_loader;

  localparam int G   = 4;
  localparam int P   = 4;
  localparam int B   = 2*G + P + 2;
  localparam int TEX = 2*G + P;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  prg_sel;
  logic [8:0]  prg_len;
  logic [15:0] base_addr;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  addr_sw, data_sw;
  logic        examine_pb, deposit_pb, deposit_next_pb, pause_req, busy, done;

  logic [7:0]  rom [0:2047];
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        pause, busy, done, exam, dep, depn;
    logic [7:0]  asw, dsw;
    logic [10:0] radr;
    logic        radr_valid;
  } exp_t;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  panel_prog_loader #(.GAP_LEN(G), .PULSE_LEN(P)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .prg_sel(prg_sel), .prg_len(prg_len),
    .base_addr(base_addr), .rom_addr(rom_addr), .rom_data(rom_data), .addr_sw(addr_sw),
    .data_sw(data_sw), .examine_pb(examine_pb), .deposit_pb(deposit_pb),
    .deposit_next_pb(deposit_next_pb), .pause_req(pause_req), .busy(busy), .done(done)
  );

  // Expected outputs t cycles after the start edge of an N-byte load (t <= 0 means idle).
  function automatic exp_t model(input int t, input int n, input logic [15:0] base, input logic [2:0] sel);
    exp_t e;
    int tfin, b, ph;
    logic [10:0] a;
    e = '0;
    tfin = (n == 0) ? 1 : TEX + n*B + 1;
    if (t == tfin) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else if (t >= 1 && t < tfin) begin
      e.pause = 1'b1;
      e.busy  = 1'b1;
      e.asw   = base[15:8];
      if (t <= TEX) begin
        e.dsw  = base[7:0];
        e.exam = (t > G) && (t <= G + P);
      end else begin
        b  = (t - TEX - 1) / B;
        ph = (t - TEX - 1) % B;
        a  = {sel, 8'(b)};
        if (ph < 2) e.dsw = (b == 0) ? base[7:0] : rom[{sel, 8'(b - 1)}];
        else        e.dsw = rom[a];
        if (ph == 0) begin
          e.radr = a;
          e.radr_valid = 1'b1;
        end
        if (ph >= G + 2 && ph < G + P + 2) begin
          e.dep  = (b == 0);
          e.depn = (b != 0);
        end
      end
    end else begin
      e.radr_valid = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int t, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
    end
  endtask

  task automatic check_all(input int t, input exp_t e);
    chk("pause_req", t, {15'd0, pause_req}, {15'd0, e.pause});
    chk("busy", t, {15'd0, busy}, {15'd0, e.busy});
    chk("done", t, {15'd0, done}, {15'd0, e.done});
    chk("examine_pb", t, {15'd0, examine_pb}, {15'd0, e.exam});
    chk("deposit_pb", t, {15'd0, deposit_pb}, {15'd0, e.dep});
    chk("deposit_next_pb", t, {15'd0, deposit_next_pb}, {15'd0, e.depn});
    chk("addr_sw", t, {8'd0, addr_sw}, {8'd0, e.asw});
    chk("data_sw", t, {8'd0, data_sw}, {8'd0, e.dsw});
    if (e.radr_valid) chk("rom_addr", t, {5'd0, rom_addr}, {5'd0, e.radr});
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      check_all(0, model(0, 0, 16'd0, 3'd0));
    end
  endtask

  // Runs one load from a start edge; abort_at > 0 returns right after checking that cycle.
  task automatic load(input logic [2:0] sel, input logic [8:0] len, input logic [15:0] base,
                      input bit retrig, input int abort_at);
    int n, tfin, ne, nd, ndn, ndone;
    logic pe, pd, pdn;
    exp_t e;
    n = (len > 9'd256) ? 256 : int'(len);
    tfin = (n == 0) ? 1 : TEX + n*B + 1;
    ne = 0; nd = 0; ndn = 0; ndone = 0;
    pe = 1'b0; pd = 1'b0; pdn = 1'b0;
    prg_sel = sel; prg_len = len; base_addr = base; start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= tfin + 3; t++) begin
      @(negedge clk);
      e = model(t, n, base, sel);
      check_all(t, e);
      if (examine_pb && !pe) ne++;
      if (deposit_pb && !pd) nd++;
      if (deposit_next_pb && !pdn) ndn++;
      if (done) ndone++;
      pe = examine_pb; pd = deposit_pb; pdn = deposit_next_pb;
      if (abort_at == t) return;
      prg_sel   = 3'($urandom);
      prg_len   = 9'($urandom);
      base_addr = 16'($urandom);
      if (!retrig) start = 1'b0;
      else if (t == TEX + B + G + 3) start = 1'b0;
      else if (t == TEX + B + G + 4) start = 1'b1;
      else start = start;
    end
    chk("done_count", tfin, 16'(ndone), 16'd1);
    chk("examine_count", tfin, 16'(ne), (n > 0) ? 16'd1 : 16'd0);
    chk("deposit_count", tfin, 16'(nd), (n > 0) ? 16'd1 : 16'd0);
    chk("deposit_next_count", tfin, 16'(ndn), (n > 0) ? 16'(n - 1) : 16'd0);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h200] = 8'h3E;
    rom[11'h201] = 8'h01;
    rom[11'h202] = 8'hD3;
    reset_n = 1'b0; start = 1'b0; prg_sel = 3'd0; prg_len = 9'd0; base_addr = 16'd0;

    // Reset held while start toggles, then release with start high.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_all(0, model(0, 0, 16'd0, 3'd0));
      start = ~start;
      prg_len = 9'd3;
    end
    @(negedge clk);
    start = 1'b1;
    reset_n = 1'b1;
    idle_cycles(8);
    start = 1'b0;
    idle_cycles(2);

    // Directed normal load.
    load(3'd2, 9'd3, 16'h0100, 1'b0, 0);
    idle_cycles(2);

    // Zero length.
    load(3'($urandom), 9'd0, 16'($urandom), 1'b0, 0);
    idle_cycles(2);

    // Retrigger during DEP_PULSE, start held high through FINISH.
    load(3'd5, 9'd3, 16'hA5C3, 1'b1, 0);
    idle_cycles(2);

    // Reset during the second DEP_PULSE, then a fresh load.
    load(3'd1, 9'd4, 16'h1234, 1'b0, TEX + B + G + 4);
    chk("depn_before_reset", -1, {15'd0, deposit_next_pb}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all(-1, model(0, 0, 16'd0, 3'd0));
    @(negedge clk);
    check_all(-1, model(0, 0, 16'd0, 3'd0));
    reset_n = 1'b1;
    start = 1'b0;
    idle_cycles(2);
    load(3'd1, 9'd4, 16'h1234, 1'b0, 0);

    // Randomized short loads.
    for (int i = 0; i < 6; i++) begin
      load(3'($urandom), 9'($urandom_range(0, 6)), 16'($urandom), 1'b0, 0);
      idle_cycles(1);
    end

    // Oversized length clamps to 256 bytes.
    load(3'd7, 9'd300, 16'($urandom), 1'b0, 0);
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panel_prog_loader.md
# panel_prog_loader

Automatic program loader for the Altair 8800 core. It sits directly upstream of the `altair` machine's front-panel inputs. On a load request it pauses the CPU and replays the operator's toggle sequence: set the start address, EXAMINE, then DEPOSIT / DEPOSIT NEXT once per byte of the selected program image. Bytes are read from a synchronous program ROM. Its outputs are OR-merged with the front-panel switch outputs before they reach the machine.

## Interface
Parameters:
- `GAP_LEN`, default 16: cycles the switches are held stable before and after each pushbutton pulse; must be ≥ 1.
- `PULSE_LEN`, default 16: cycles each pushbutton output is held high; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  load request; level input, rising edge detected internally.
- `prg_sel`  in  3  program select; latched on the accepted start edge.
- `prg_len`  in  9  image length in bytes, 0..256; values above 256 are clamped to 256; latched on the accepted start edge.
- `base_addr`  in  16  load and examine address; latched on the accepted start edge.
- `rom_addr`  out  11  `{prg_sel_latched, idx[7:0]}`.
- `rom_data`  in  8  ROM byte, valid 1 cycle after `rom_addr`.
- `addr_sw`  out  8  drives the high address switches (`addrOrSenseIn`).
- `data_sw`  out  8  drives the data / low address switches (`dataOraddrIn`).
- `examine_pb`, `deposit_pb`, `deposit_next_pb`  out  1 each  pushbutton pulses.
- `pause_req`  out  1  forces STOP; OR-merged into `pauseModeSW`.
- `busy`  out  1  high from EXAM_SETUP through FINISH inclusive.
- `done`  out  1  one-cycle completion pulse.

## Operation
States: IDLE, EXAM_SETUP, EXAM_PULSE, EXAM_HOLD, FETCH, CAPTURE, DEP_SETUP, DEP_PULSE, DEP_HOLD, FINISH.

- **IDLE**
  - All outputs 0.
  - On a `start` rising edge: latch `prg_sel`, the clamped `prg_len` (N) and `base_addr`; set `idx` = 0.
  - If N == 0, go to FINISH. Otherwise go to EXAM_SETUP.
- **EXAM_SETUP / EXAM_PULSE / EXAM_HOLD**
  - `addr_sw` = `base[15:8]` and `data_sw` = `base[7:0]` for all three states.
  - Dwell GAP_LEN, PULSE_LEN and GAP_LEN cycles respectively.
  - `examine_pb` = 1 only in EXAM_PULSE.
- **FETCH** (1 cycle): `rom_addr` presents `idx`. `data_sw` is unchanged.
- **CAPTURE** (1 cycle): `data_sw` <= `rom_data` at the end of the cycle. `addr_sw` stays at `base[15:8]` for the whole load.
- **DEP_SETUP / DEP_PULSE / DEP_HOLD**
  - Dwell GAP_LEN, PULSE_LEN and GAP_LEN cycles.
  - In DEP_PULSE, `deposit_pb` = 1 when `idx` == 0; otherwise `deposit_next_pb` = 1.
  - Leaving DEP_HOLD: if `idx` == N−1 go to FINISH; else `idx`++ and go to FETCH.
- **FINISH** (1 cycle)
  - `done` = 1 and `busy` = 1.
  - `addr_sw`, `data_sw` and `pause_req` are already 0.
  - Next state is IDLE.
- `pause_req` = 1 in every state except IDLE and FINISH.
- At most one pushbutton output is high in any cycle.
- `start` edges seen outside IDLE are ignored and not queued. A `start` held high after FINISH does not retrigger; a new low→high transition is required.
- `prg_sel`, `prg_len` and `base_addr` changes after the latch have no effect until the next accepted start.
- Dwell counter width: clog2(max(GAP_LEN, PULSE_LEN)) + 1. `idx` is 8 bits; N = 256 ends at `idx` = 0xFF without wrapping.

## Timing
- Reset: asynchronous. Every output is 0 and the state is IDLE immediately on `reset_n` = 0, including mid-pulse. The `start` edge detector's history register resets to 1, so a `start` already high at release is not taken as an edge.
- Timeline, with the start edge sampled at clock k and cycles counted from k+1:
  - EXAM_SETUP occupies k+1 .. k+G.
  - Each byte costs 2G+P+2 cycles.
  - FINISH falls at k + 2G + P + N·(2G+P+2) + 1.
- N == 0: FINISH (and `done`) at k+1 with no pushbutton activity.
- Switch outputs are stable for ≥ G cycles on both sides of every pulse.
- `done` next pulses only after a new accepted start.

## Test plan
- Reset: hold `reset_n` = 0 while `start` toggles → all outputs 0 and `rom_addr` = 0. Release with `start` high → no load begins.
- Normal load: G = P = 4, N = 3, `base_addr` = 0x0100, `prg_sel` = 2, ROM bytes 0x3E, 0x01, 0xD3; start edge at cycle 0. Required:
  - `examine_pb` high at cycles 5..8 with `addr_sw` = 0x01, `data_sw` = 0x00.
  - `deposit_pb` once with `data_sw` = 0x3E; `deposit_next_pb` twice with 0x01 then 0xD3.
  - `rom_addr` = 0x200, 0x201, 0x202 in turn.
  - `done` at cycle 55; `pause_req` high for cycles 1..54.
- Zero length: N = 0 → `done` at cycle 1; no pushbutton pulse; `pause_req` never asserts.
- Ignored retrigger: toggle `start` during DEP_PULSE, then hold it high through FINISH → exactly one load and one `done`.
- Mid-operation reset: drop `reset_n` during the second DEP_PULSE → `deposit_next_pb` and `pause_req` fall in the same cycle. A fresh start then reloads from byte 0, beginning with examine.
- Maximum length: `prg_len` = 300, `prg_sel` = 7 → treated as 256. Required: 1 examine, 1 deposit, 255 deposit_next; last `rom_addr` = 0x7FF; `done` once.
